fft_bitrev_loader: RTL and testbench

- Input stage of the FFT datapath. Collects N real audio samples and packs each into the complex word format {real[WIDTH-1:WIDTH/2], imag[WIDTH/2-1:0]} with imag = 0.
- Stores each sample at the bit-reversed address of its arrival index.
- Streams the frame out in linear address order, so the butterfly array receives bit-reversed input and produces natural-order output.
- Frame-based: fills, drains, then refills.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_bitrev_loader_if.sv | 28 ++
 rtl/fft_frame_ram.sv | 26 ++
 rtl/fft_bitrev_loader.sv | 136 +++++++++++++
 tb/tb_fft_bitrev_loader.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input loader: frame geometry, complex word layout,
// loader states and the index bit-reversal used to scramble the frame.
package fft_pkg;

  localparam int WIDTH     = 36;
  localparam int N         = 256;
  localparam int LOG2N     = 8;
  localparam int LOG2N_MAX = 16;

  typedef struct packed {
    logic signed [WIDTH/2-1:0] re;
    logic signed [WIDTH/2-1:0] im;
  } cplx_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } loader_state_t;

  // Reverses the low nbits of idx; bits at and above nbits come back as zero.
  function automatic logic [LOG2N_MAX-1:0] bitrev(input logic [LOG2N_MAX-1:0] idx,
                                                  input int nbits);
    logic [LOG2N_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N_MAX; i++) begin
      if (i < nbits) r[i] = idx[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_loader_if.sv
// Sample-in / complex-word-out stream bundle of the FFT loader.
// master = environment side (upstream source plus downstream sink), slave = loader.
interface fft_bitrev_loader_if #(
  parameter int WIDTH = fft_pkg::WIDTH,
  parameter int LOG2N = fft_pkg::LOG2N
);

  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH/2-1:0] in_sample;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [LOG2N-1:0]          out_index;
  logic                      out_last;
  logic                      overrun;

  modport master (
    output in_valid, in_sample, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, overrun
  );

  modport slave (
    input  in_valid, in_sample, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, overrun
  );

endinterface

// File: rtl/fft_frame_ram.sv
// N x WIDTH simple dual-port frame buffer: one write port, one registered read port.
module fft_frame_ram #(
  parameter int WIDTH = fft_pkg::WIDTH,
  parameter int N     = fft_pkg::N,
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [LOG2N-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [LOG2N-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [N];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_bitrev_loader.sv
// FFT input stage: writes real samples to bit-reversed addresses, then streams the frame
// out in linear order through a 2-entry skid so downstream backpressure never drops words.
module fft_bitrev_loader #(
  parameter int WIDTH = fft_pkg::WIDTH,
  parameter int N     = fft_pkg::N,
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input logic          clk,
  input logic          rst_n,
  fft_bitrev_loader_if.slave bus
);
  import fft_pkg::*;

  localparam int HALF = WIDTH / 2;

  loader_state_t    r_state, w_state_nxt;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [LOG2N:0]   r_rd_addr;
  logic             w_in_ready, w_wr_en, w_rd_en, w_pop, w_room, w_frame_end;
  logic [LOG2N-1:0] w_wr_addr;
  logic [WIDTH-1:0] w_wr_data, w_rd_data;
  logic [1:0]       w_occ;

  logic             r_rd_pend;
  logic [LOG2N-1:0] r_pend_idx;
  logic             r_out_valid, r_out_last, r_sk_valid, r_sk_last, r_overrun;
  logic [LOG2N-1:0] r_out_index, r_sk_index;
  logic [WIDTH-1:0] r_out_data, r_sk_data;
  logic             w_head_ld, w_head_from_sk, w_sk_ld, w_out_valid_nxt, w_sk_valid_nxt;

  // Write side: handshake only in FILL, sample goes to the real half.
  assign w_in_ready = (r_state == FILL) && rst_n;
  assign w_wr_en    = bus.in_valid && w_in_ready;
  assign w_wr_addr  = LOG2N'(bitrev(LOG2N_MAX'(r_wr_cnt), LOG2N));
  assign w_wr_data  = {bus.in_sample, {HALF{1'b0}}};

  // Read side: issue only while the skid can hold every word already in flight.
  assign w_pop       = r_out_valid && bus.out_ready;
  assign w_frame_end = w_pop && r_out_last;
  assign w_occ       = {1'b0, r_out_valid} + {1'b0, r_sk_valid} + {1'b0, r_rd_pend};
  assign w_room      = (w_occ < 2'd2) || (w_pop && (w_occ == 2'd2));
  assign w_rd_en     = (r_state == DRAIN) && !r_rd_addr[LOG2N] && w_room;

  fft_frame_ram #(.WIDTH(WIDTH), .N(N), .LOG2N(LOG2N)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_addr),
    .i_wdata (w_wr_data),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_addr[LOG2N-1:0]),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_wr_en && (r_wr_cnt == LOG2N'(N-1))) w_state_nxt = DRAIN;
      DRAIN:   if (w_frame_end) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    w_head_ld       = 1'b0;
    w_head_from_sk  = 1'b0;
    w_sk_ld         = 1'b0;
    w_out_valid_nxt = r_out_valid;
    w_sk_valid_nxt  = r_sk_valid;
    if (!r_out_valid || w_pop) begin
      if (r_sk_valid) begin
        w_head_from_sk  = 1'b1;
        w_out_valid_nxt = 1'b1;
        w_sk_ld         = r_rd_pend;
        w_sk_valid_nxt  = r_rd_pend;
      end else begin
        w_head_ld       = r_rd_pend;
        w_out_valid_nxt = r_rd_pend;
      end
    end else if (r_rd_pend) begin
      w_sk_ld        = 1'b1;
      w_sk_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_wr_cnt    <= '0;
      r_rd_addr   <= '0;
      r_rd_pend   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en) begin
        if (r_wr_cnt == LOG2N'(N-1)) r_wr_cnt <= '0;
        else                         r_wr_cnt <= r_wr_cnt + LOG2N'(1);
      end
      if (w_frame_end)  r_rd_addr <= '0;
      else if (w_rd_en) r_rd_addr <= r_rd_addr + (LOG2N+1)'(1);
      r_rd_pend   <= w_rd_en;
      r_out_valid <= w_out_valid_nxt;
      r_sk_valid  <= w_sk_valid_nxt;
      if (w_head_from_sk) begin
        r_out_index <= r_sk_index;
        r_out_last  <= r_sk_last;
      end else if (w_head_ld) begin
        r_out_index <= r_pend_idx;
        r_out_last  <= (r_pend_idx == LOG2N'(N-1));
      end
      if (bus.in_valid && (r_state == DRAIN)) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_en) r_pend_idx <= r_rd_addr[LOG2N-1:0];
    if (w_head_from_sk)  r_out_data <= r_sk_data;
    else if (w_head_ld)  r_out_data <= w_rd_data;
    if (w_sk_ld) begin
      r_sk_data  <= w_rd_data;
      r_sk_index <= r_pend_idx;
      r_sk_last  <= (r_pend_idx == LOG2N'(N-1));
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;
  assign bus.out_last  = r_out_last;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Bench for fft_bitrev_loader with N = 8: directed frames plus a frame-level reference model
// that predicts every output word, in_ready and the overrun flag each cycle.
module tb_fft_bitrev_loader;
  import fft_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  bit   mon_en;

  fft_bitrev_loader_if #(.WIDTH(36), .LOG2N(3)) bus ();

  fft_bitrev_loader #(.WIDTH(36), .N(8), .LOG2N(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: frame-level view of the loader.
  bit          m_fill;
  bit          m_over;
  int          m_wr;
  int          m_rd;
  logic [17:0] m_samp [8];
  logic [17:0] m_frame [8];
  cplx_t       cw;

  logic [35:0] got_w [8];
  int          got_n;
  int          exp_v [8];
  int          perm [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Monitor: check outputs against the model, then advance the model for the coming edge.
  initial begin
    m_fill = 1'b1; m_over = 1'b0; m_wr = 0; m_rd = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("in_ready", 64'(bus.in_ready), 64'(m_fill && rst_n));
        chk("overrun", 64'(bus.overrun), 64'(m_over));
        if (m_fill) begin
          chk("out_valid_idle", 64'(bus.out_valid), 64'(0));
        end else if (bus.out_valid) begin
          cw = bus.out_data;
          chk("out_data", 64'(bus.out_data), 64'({m_frame[m_rd], 18'h0}));
          chk("out_index", 64'(bus.out_index), 64'(m_rd));
          chk("out_last", 64'(bus.out_last), 64'(m_rd == 7));
          chk("out_imag", 64'(cw.im), 64'(0));
        end
      end
      if (!rst_n) begin
        m_fill = 1'b1; m_over = 1'b0; m_wr = 0; m_rd = 0;
      end else if (m_fill) begin
        if (bus.in_valid) begin
          m_samp[m_wr] = bus.in_sample;
          m_wr++;
          if (m_wr == 8) begin
            for (int k = 0; k < 8; k++)
              m_frame[k] = m_samp[(k % 2) * 4 + ((k / 2) % 2) * 2 + k / 4];
            m_fill = 1'b0; m_wr = 0; m_rd = 0;
          end
        end
      end else begin
        if (bus.in_valid) m_over = 1'b1;
        if (bus.out_valid && bus.out_ready) begin
          m_rd++;
          if (m_rd == 8) m_fill = 1'b1;
        end
      end
    end
  end

  task automatic push(input logic [17:0] v);
    int t;
    t = 0;
    bus.in_valid  = 1'b1;
    bus.in_sample = v;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout_fail("push_wait");
    @(posedge clk); #1;
  endtask

  task automatic drain(input logic [3:0] pat, output int cycles);
    int c;
    c = 0;
    got_n = 0;
    while (got_n < 8 && c < 300) begin
      bus.out_ready = pat[c % 4];
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got_w[got_n] = bus.out_data;
        got_n++;
      end
      @(posedge clk); #1;
      c++;
    end
    bus.out_ready = 1'b0;
    if (got_n < 8) timeout_fail("drain_wait");
    cycles = c;
  endtask

  task automatic chk_frame(input string name);
    for (int k = 0; k < 8; k++)
      chk(name, 64'(got_w[k]), 64'({exp_v[k][17:0], 18'h0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    n_checks = 0; n_fail = 0; mon_en = 1'b0;
    perm = '{0, 4, 2, 6, 1, 5, 3, 7};
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_sample = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_index", 64'(bus.out_index), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_overrun", 64'(bus.overrun), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1 chk("in_ready_after_rst", 64'(bus.in_ready), 64'(1));

    // Frame 1: samples 1..8, latency and bit-reversed order.
    for (int i = 1; i <= 8; i++) push(18'(i));
    bus.in_valid = 1'b0;
    chk("lat_t1_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_t2_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_t3_valid", 64'(bus.out_valid), 64'(1));
    chk("first_word", 64'(bus.out_data), 64'(36'h0_0004_0000));
    drain(4'b1111, cyc);
    chk("frame1_cycles", 64'(cyc), 64'(8));
    exp_v = '{1, 5, 3, 7, 2, 6, 4, 8};
    chk_frame("frame1_order");
    chk("in_ready_after_last", 64'(bus.in_ready), 64'(1));

    // Negative sample at arrival index 1 lands at out_index 4.
    push(18'(100)); push(18'h3FFFF);
    for (int i = 2; i < 8; i++) push(18'(100 + i));
    bus.in_valid = 1'b0;
    drain(4'b1111, cyc);
    chk("neg_word_idx4", 64'(got_w[4]), 64'(36'hF_FFFC_0000));
    exp_v = '{100, 104, 102, 106, -1, 105, 103, 107};
    chk_frame("neg_frame");

    // Backpressure pattern 1,0,0,1 during drain.
    for (int i = 11; i <= 18; i++) push(18'(i));
    bus.in_valid = 1'b0;
    drain(4'b1001, cyc);
    exp_v = '{11, 15, 13, 17, 12, 16, 14, 18};
    chk_frame("bp_frame");

    // Overrun: in_valid held through DRAIN.
    for (int i = 21; i <= 28; i++) push(18'(i));
    bus.in_sample = 18'(99);
    chk("ovr_before", 64'(bus.overrun), 64'(0));
    @(posedge clk); #1;
    chk("ovr_first_drain", 64'(bus.overrun), 64'(1));
    drain(4'b1111, cyc);
    exp_v = '{21, 25, 23, 27, 22, 26, 24, 28};
    chk_frame("ovr_frame1");
    for (int i = 31; i <= 38; i++) push(18'(i));
    bus.in_valid = 1'b0;
    drain(4'b1111, cyc);
    exp_v = '{31, 35, 33, 37, 32, 36, 34, 38};
    chk_frame("ovr_frame2");
    chk("ovr_sticky", 64'(bus.overrun), 64'(1));

    // Reset in the middle of a fill.
    for (int i = 41; i <= 45; i++) push(18'(i));
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_overrun", 64'(bus.overrun), 64'(0));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    for (int i = 51; i <= 58; i++) push(18'(i));
    bus.in_valid = 1'b0;
    drain(4'b1111, cyc);
    exp_v = '{51, 55, 53, 57, 52, 56, 54, 58};
    chk_frame("rst_frame");
    chk("rst_frame_overrun", 64'(bus.overrun), 64'(0));

    // Three back-to-back frames, in_valid continuous and gated by in_ready.
    fork
      begin
        for (int i = 0; i < 24; i++) push(18'(61 + i));
        bus.in_valid = 1'b0;
      end
      begin
        int c2;
        for (int f = 0; f < 3; f++) begin
          drain(4'b1111, c2);
          for (int k = 0; k < 8; k++) exp_v[k] = 61 + 8 * f + perm[k];
          chk_frame("b2b_frame");
        end
      end
    join
    chk("b2b_overrun", 64'(bus.overrun), 64'(1));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
